// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbiter that lends one shared up-counter to one requester at a time for a run of N cycles
module counter_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    input  logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_reset,
    output logic                  cnt_enable
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [IW-1:0]    ptr, cur, win;
    logic [WIDTH-1:0] run_len;
    logic [NREQ-1:0]  cur_oh;
    // winner is the first set req bit at or after ptr; scanning backwards lets the nearest one overwrite
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[IW'((int'(ptr) + k) % NREQ)]) win = IW'((int'(ptr) + k) % NREQ);
    end
    // next-state decode; run_len==0 skips RUN entirely
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |req ? CLEAR : IDLE;
            CLEAR:   state_n = (run_len == '0) ? DONE : RUN;
            RUN:     state_n = (count == run_len - WIDTH'(1)) ? DONE : RUN;
            default: state_n = IDLE;
        endcase
    end
    // state register plus grant bookkeeping; len is captured only at the grant edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cur     <= '0;
            run_len <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && |req) begin
                cur     <= win;
                run_len <= len[int'(win)*WIDTH +: WIDTH];
            end
            if (state == DONE) ptr <= (cur == IW'(NREQ - 1)) ? '0 : cur + IW'(1);
        end
    end
    assign cur_oh     = {{(NREQ-1){1'b0}}, 1'b1} << cur;
    assign busy       = state != IDLE;
    assign gnt        = busy ? cur_oh : '0;
    assign done       = (state == DONE) ? cur_oh : '0;
    assign cnt_reset  = state == CLEAR;
    assign cnt_enable = state == RUN;
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed checks of counter_scheduler against a shared 4-bit counter model
module tb_counter_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  count;
    logic [3:0]  gnt, done;
    logic        busy, cnt_reset, cnt_enable;
    int          n_tests = 0;
    int          n_fail  = 0;

    counter_scheduler #(.NREQ(4), .WIDTH(4)) dut (
        .clock(clock), .reset(reset), .req(req), .len(len), .count(count),
        .gnt(gnt), .done(done), .busy(busy), .cnt_reset(cnt_reset), .cnt_enable(cnt_enable)
    );

    always #5 clock = ~clock;

    // shared counter driven only by the scheduler (bench reset just gives it a known start)
    always_ff @(posedge clock) begin
        if (reset || cnt_reset) count <= '0;
        else if (cnt_enable) count <= count + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // one full grant from the IDLE cycle: CLEAR, n RUN cycles, DONE, then the mandatory IDLE
    task automatic serve(input int w, input int n, input logic [3:0] req_mid, input logic [15:0] len_mid);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        step();
        check("clr_gnt", gnt, oh);
        check("clr_rst", cnt_reset, 1);
        check("clr_en", cnt_enable, 0);
        check("clr_busy", busy, 1);
        req = req_mid;
        len = len_mid;
        for (int i = 0; i < n; i++) begin
            step();
            check("run_gnt", gnt, oh);
            check("run_en", cnt_enable, 1);
            check("run_rst", cnt_reset, 0);
            check("run_done", done, 0);
            check("run_cnt", count, i);
        end
        step();
        check("dn_gnt", gnt, oh);
        check("dn_done", done, oh);
        check("dn_en", cnt_enable, 0);
        check("dn_cnt", count, n);
        step();
        check("idle_busy", busy, 0);
        check("idle_gnt", gnt, 0);
        check("idle_done", done, 0);
        check("idle_cnt", count, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        len   = '0;
        do_reset();
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_crst", cnt_reset, 0);
        check("rst_en", cnt_enable, 0);
        // single request, length 5
        req = 4'b0001;
        len = 16'h0005;
        serve(0, 5, 4'b0000, 16'h0005);
        // zero length on requester 1
        req = 4'b0010;
        len = 16'h0000;
        serve(1, 0, 4'b0000, 16'h0000);
        // fairness after reset with all requesters held high
        do_reset();
        req = 4'b1111;
        len = 16'h2222;
        for (int w = 0; w < 4; w++) serve(w, 2, 4'b1111, 16'h2222);
        // ptr wrapped back to 0: maximum length run
        req = 4'b1001;
        len = 16'h222F;
        serve(0, 15, 4'b0000, 16'h222F);
        // withdrawal and len change during RUN do not disturb requester 2
        req = 4'b0100;
        len = 16'h0300;
        serve(2, 3, 4'b0000, 16'h0100);
        // reset on the 3rd RUN cycle aborts the run
        req = 4'b1111;
        len = 16'h4444;
        step();
        check("ab_gnt", gnt, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ab_run_en", cnt_enable, 1);
            check("ab_run_done", done, 0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ab_gnt0", gnt, 0);
        check("ab_done0", done, 0);
        check("ab_busy0", busy, 0);
        check("ab_en0", cnt_enable, 0);
        step();
        check("ab_regrant", gnt, 4'b0001);
        check("ab_regrant_rst", cnt_reset, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Round-robin scheduler that shares one 4-bit up-counter (synchronous active-high reset, active-high enable) between several requesters. Each requester asks for a run of N counting cycles. The scheduler grants one requester at a time, clears the counter, enables it for exactly N cycles, then signals completion. It sits between the requester logic and the shared counter and is the only driver of the counter's reset and enable inputs.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 4: counter width; also the width of each run length.

- clock  in  1  design clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- req  in  NREQ  level request per requester; bit i = requester i.
- len  in  NREQ*WIDTH  run length per requester, slice i = len[i*WIDTH +: WIDTH]; sampled only at grant.
- count  in  WIDTH  current value of the shared counter.
- gnt  out  NREQ  one-hot grant; all zero when idle.
- done  out  NREQ  one-hot, one-cycle completion pulse to the granted requester.
- busy  out  1  high in any state other than IDLE.
- cnt_reset  out  1  drives the counter's reset input.
- cnt_enable  out  1  drives the counter's enable input.

## Operation
- All outputs are registered or decoded from registered state. No combinational path exists from req or count to any output.
- The counter model is: posedge with cnt_reset → count=0; otherwise posedge with cnt_enable → count+1.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - gnt=0, done=0, busy=0, cnt_reset=0, cnt_enable=0.
  - If any req bit is set, select a winner round-robin starting at ptr, latch its index into cur and its len slice into run_len, then go to CLEAR.
- CLEAR:
  - gnt[cur]=1, busy=1, cnt_reset=1 for exactly one cycle.
  - Next state is DONE if run_len==0, else RUN.
- RUN:
  - gnt[cur]=1, busy=1, cnt_enable=1.
  - When count==run_len-1, go to DONE; that same edge increments count to run_len.
- DONE:
  - gnt[cur]=1, busy=1, done[cur]=1, cnt_enable=0.
  - Set ptr=(cur+1) mod NREQ, then go to IDLE.
- Round-robin rule: the winner is the first set req bit at or after ptr, wrapping around. ptr resets to 0, so requester 0 has first priority after reset.
- Requests are level-sensitive. Deasserting req while granted does not abort the run; it completes and done still pulses.
- len and req changes during CLEAR, RUN or DONE are ignored.
- A requester that holds req high after done competes again in the next IDLE cycle. ptr has already advanced past it.
- After DONE, count holds run_len until the next CLEAR, because cnt_enable is low.
- Width rules:
  - run_len is at most 2^WIDTH-1, so count never wraps within a run.
  - The comparison count==run_len-1 is done in WIDTH bits and is only evaluated when run_len≠0.

## Timing
- Reset values: state=IDLE, ptr=0, cur=0, run_len=0; gnt=0, done=0, busy=0, cnt_reset=0, cnt_enable=0.
- Reset mid-operation:
  - Takes effect on the next posedge regardless of state.
  - No done pulse is produced for the aborted run.
  - cnt_enable is low from the cycle after the reset edge.
- Request to grant: req sampled high at edge E0 (state IDLE) → gnt and cnt_reset high in the cycle after E0.
- Run length:
  - Exactly run_len cycles with cnt_enable=1.
  - One DONE cycle follows; at the start of that cycle count==run_len.
- Grant occupancy: run_len+2 cycles (CLEAR + RUN + DONE). A mandatory IDLE cycle follows.
  - Back-to-back grant period: run_len+3 cycles.
  - run_len=0 gives a period of 3 cycles with no enable cycle.
- Simultaneous requests: only one grant per IDLE cycle, chosen by the ptr order.
- gnt stays stable and one-hot from CLEAR through DONE inclusive.

## Test plan
- Single request: reset, then req=0001, len0=5 → gnt=0001 for 7 cycles. cnt_reset high 1 cycle, then cnt_enable high 5 cycles. done=0001 is a single pulse with count=5. busy returns to 0.
- Zero length: req=0010, len1=0 → CLEAR then DONE. cnt_enable is never high, done=0010 pulses, count=0.
- Fairness: req=1111 held, all len=2, NREQ=4 → grant order 0,1,2,3,0,… Each done pulse matches its grant, and the grant period is 5 cycles.
- Wrap and maximum length: after requester 3 is served, req=1001, len0=15 → requester 0 is granted next. 15 enable cycles, count=15 at done, no wrap.
- Withdrawal: req2 is dropped during RUN → the run completes and done=0100 still pulses. len changes during RUN have no effect.
- Reset mid-run: reset asserted on the 3rd RUN cycle → outputs return to 0 on the next edge, no done pulse, ptr=0. A subsequent req=1111 grants requester 0 first.
